// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings, register index type, control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] reg_idx_t;
  localparam reg_idx_t REG_ZERO = 5'd0;

  // Memory-wait FSM encodings (kept as plain constants for legacy tools)
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR      = 2'd2;

  // Which priority level drives the control outputs this cycle
  typedef enum logic [2:0] {
    SEL_RESET  = 3'd0,
    SEL_ERR    = 3'd1,
    SEL_FREEZE = 3'd2,
    SEL_STALL  = 3'd3,
    SEL_XFER   = 3'd4,
    SEL_RUN    = 3'd5
  } ctl_sel_e;

  // Control bundle, in output port order
  typedef struct packed {
    logic pc_write;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_flush;
    logic pipe_freeze;
    logic hazard_err;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_stall: 1'b0, ifid_flush: 1'b1,
                                    idex_flush: 1'b1, pipe_freeze: 1'b0, hazard_err: 1'b0};
  localparam ctrl_t CTRL_ERR    = '{pc_write: 1'b0, ifid_stall: 1'b1, ifid_flush: 1'b0,
                                    idex_flush: 1'b0, pipe_freeze: 1'b1, hazard_err: 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_stall: 1'b1, ifid_flush: 1'b0,
                                    idex_flush: 1'b0, pipe_freeze: 1'b1, hazard_err: 1'b0};
  localparam ctrl_t CTRL_STALL  = '{pc_write: 1'b0, ifid_stall: 1'b1, ifid_flush: 1'b0,
                                    idex_flush: 1'b1, pipe_freeze: 1'b0, hazard_err: 1'b0};
  localparam ctrl_t CTRL_XFER   = '{pc_write: 1'b1, ifid_stall: 1'b0, ifid_flush: 1'b1,
                                    idex_flush: 1'b0, pipe_freeze: 1'b0, hazard_err: 1'b0};
  localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_stall: 1'b0, ifid_flush: 1'b0,
                                    idex_flush: 1'b0, pipe_freeze: 1'b0, hazard_err: 1'b0};

endpackage

// File: rtl/hazard_match.sv
// Compares a producer destination register against the ID-stage source fields; $0 never matches.
// Latency: purely combinational.
// Backpressure: none.
module hazard_match
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] r,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             hit
);

  // rs is always a source; rt only when the instruction actually reads it
  always_comb begin
    hit = (r != REG_ZERO) && ((r == id_rs) || (id_uses_rt && (r == id_rt)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: load-use and branch-operand hazards, control-transfer flushes, dmem wait FSM with timeout.
// Latency: outputs are combinational from current inputs and FSM state; state advances on posedge clk.
// Backpressure: dmemBusy freezes the pipe and masks hazards until release. Optional HAZARD_PERF_CNT_EN adds perf counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int WAIT_W      = 8,
  parameter int PERF_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             idUsesRt,
  input  logic             idBranch,
  input  logic             idBranchTaken,
  input  logic             idJump,
  input  logic             exMemRead,
  input  logic             exRegWrite,
  input  logic [REG_W-1:0] exRd,
  input  logic             memMemRead,
  input  logic [REG_W-1:0] memRd,
  input  logic             dmemBusy,
  output logic             pcWrite,
  output logic             ifidStall,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic             pipeFreeze,
  output logic             hazardErr
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] loadUseCnt,
  output logic [PERF_W-1:0] branchStallCnt,
  output logic [PERF_W-1:0] memWaitCnt,
  output logic [PERF_W-1:0] flushCnt
`endif
);

  // The wait counter must be able to reach MEM_TIMEOUT-1
  if (((1 << WAIT_W) <= MEM_TIMEOUT) || (MEM_TIMEOUT < 1) || (PERF_W < 1)) begin : g_bad_params
    $error("pipeline_hazard_ctrl: need 1 <= MEM_TIMEOUT < 2**WAIT_W and PERF_W >= 1");
  end

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic     ex_hit_lu, ex_hit_br, mem_hit_br;
  logic     load_use, branch_haz, ctl_xfer;
  ctl_sel_e sel;
  ctrl_t    ctl;

  hazard_match u_match_ex_lu (
    .r(exRd), .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt), .hit(ex_hit_lu)
  );
  hazard_match u_match_ex_br (
    .r(exRd), .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt), .hit(ex_hit_br)
  );
  hazard_match u_match_mem_br (
    .r(memRd), .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt), .hit(mem_hit_br)
  );

  // Hazard terms: branches compare in ID, so any EX writer or a load still in MEM blocks them
  always_comb begin
    load_use   = exMemRead && ex_hit_lu;
    branch_haz = idBranch && ((exRegWrite && ex_hit_br) || (memMemRead && mem_hit_br));
    ctl_xfer   = (idBranch && idBranchTaken) || idJump;
  end

  // Memory-wait FSM: counts consecutive busy cycles in MEM_WAIT, ERR traps until reset
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (dmemBusy) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        if (!dmemBusy) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // FSM registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Output priority: reset, error trap, memory freeze, hazard stall, control transfer, run
  always_comb begin
    if (reset) begin
      sel = SEL_RESET;
    end else if (state_q == ST_ERR) begin
      sel = SEL_ERR;
    end else if (dmemBusy) begin
      sel = SEL_FREEZE;
    end else if (load_use || branch_haz) begin
      sel = SEL_STALL;
    end else if (ctl_xfer) begin
      sel = SEL_XFER;
    end else begin
      sel = SEL_RUN;
    end
  end

  // Decode the selected level into the control bundle
  always_comb begin
    case (sel)
      SEL_RESET:  ctl = CTRL_RESET;
      SEL_ERR:    ctl = CTRL_ERR;
      SEL_FREEZE: ctl = CTRL_FREEZE;
      SEL_STALL:  ctl = CTRL_STALL;
      SEL_XFER:   ctl = CTRL_XFER;
      SEL_RUN:    ctl = CTRL_RUN;
      default:    ctl = CTRL_RESET;
    endcase
  end

  assign pcWrite    = ctl.pc_write;
  assign ifidStall  = ctl.ifid_stall;
  assign ifidFlush  = ctl.ifid_flush;
  assign idexFlush  = ctl.idex_flush;
  assign pipeFreeze = ctl.pipe_freeze;
  assign hazardErr  = ctl.hazard_err;

`ifdef HAZARD_PERF_CNT_EN
  // Index order: load-use stall, branch-only stall, memory freeze, control-transfer flush
  logic [3:0]        perf_fire;
  logic [PERF_W-1:0] perf_q [4];
  logic [PERF_W-1:0] perf_d [4];

  // A stall caused by both terms is charged to load-use only
  always_comb begin
    perf_fire[0] = (sel == SEL_STALL) && load_use;
    perf_fire[1] = (sel == SEL_STALL) && !load_use;
    perf_fire[2] = (sel == SEL_FREEZE);
    perf_fire[3] = (sel == SEL_XFER);
  end

  // Saturating increment so a wrapped counter never under-reports
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      perf_d[i] = perf_q[i];
      if (perf_fire[i] && (perf_q[i] != {PERF_W{1'b1}})) begin
        perf_d[i] = perf_q[i] + PERF_W'(1);
      end
    end
  end

  // Counter registers with synchronous reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        perf_q[i] <= '0;
      end else begin
        perf_q[i] <= perf_d[i];
      end
    end
  end

  assign loadUseCnt     = perf_q[0];
  assign branchStallCnt = perf_q[1];
  assign memWaitCnt     = perf_q[2];
  assign flushCnt       = perf_q[3];
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4; expected control vectors queued per driven cycle.
// Latency: outputs compared on the falling edge of the cycle in which inputs were driven.
// Backpressure: n/a. Build with +define+HAZARD_PERF_CNT_EN to also check counter clearing.
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int PERF_W      = 16;

  // {pcWrite, ifidStall, ifidFlush, idexFlush, pipeFreeze, hazardErr}
  localparam logic [5:0] V_RST   = 6'b001100;
  localparam logic [5:0] V_RUN   = 6'b100000;
  localparam logic [5:0] V_STALL = 6'b010100;
  localparam logic [5:0] V_XFER  = 6'b101000;
  localparam logic [5:0] V_FRZ   = 6'b010010;
  localparam logic [5:0] V_ERR   = 6'b010011;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       br;
    logic       taken;
    logic       jmp;
    logic       ex_mr;
    logic       ex_rw;
    logic [4:0] ex_rd;
    logic       mem_mr;
    logic [4:0] mem_rd;
    logic       busy;
  } in_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] idRs, idRt, exRd, memRd;
  logic       idUsesRt, idBranch, idBranchTaken, idJump;
  logic       exMemRead, exRegWrite, memMemRead, dmemBusy;
  logic       pcWrite, ifidStall, ifidFlush, idexFlush, pipeFreeze, hazardErr;
`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] loadUseCnt, branchStallCnt, memWaitCnt, flushCnt;
`endif

  int passed = 0;
  int total  = 0;
  logic [5:0] sb[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .WAIT_W(8),
    .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .reset(reset),
    .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .idBranch(idBranch), .idBranchTaken(idBranchTaken), .idJump(idJump),
    .exMemRead(exMemRead), .exRegWrite(exRegWrite), .exRd(exRd),
    .memMemRead(memMemRead), .memRd(memRd), .dmemBusy(dmemBusy),
    .pcWrite(pcWrite), .ifidStall(ifidStall), .ifidFlush(ifidFlush),
    .idexFlush(idexFlush), .pipeFreeze(pipeFreeze), .hazardErr(hazardErr)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .loadUseCnt(loadUseCnt), .branchStallCnt(branchStallCnt),
    .memWaitCnt(memWaitCnt), .flushCnt(flushCnt)
`endif
  );

  task automatic drive(input in_t s);
    reset = s.rst; idRs = s.rs; idRt = s.rt; idUsesRt = s.uses_rt;
    idBranch = s.br; idBranchTaken = s.taken; idJump = s.jmp;
    exMemRead = s.ex_mr; exRegWrite = s.ex_rw; exRd = s.ex_rd;
    memMemRead = s.mem_mr; memRd = s.mem_rd; dmemBusy = s.busy;
  endtask

  function automatic logic [5:0] outs();
    return {pcWrite, ifidStall, ifidFlush, idexFlush, pipeFreeze, hazardErr};
  endfunction

  task automatic test_reset();
    in_t st[$]; logic [5:0] xp[$]; in_t s; logic [5:0] got, want;
    s = '0; s.rst = 1'b1; st.push_back(s); xp.push_back(V_RST);
    st.push_back(s); xp.push_back(V_RST);
    s.ex_mr = 1'b1; s.ex_rw = 1'b1; s.ex_rd = 5'd8; s.rs = 5'd8; s.busy = 1'b1; s.jmp = 1'b1;
    st.push_back(s); xp.push_back(V_RST);
    s = '0; st.push_back(s); xp.push_back(V_RUN);
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1; drive(st[i]); sb.push_back(xp[i]);
      @(negedge clk);
      got = outs(); want = sb.pop_front(); total++;
      if (got === want) passed++;
      else $display("FAIL reset[%0d]: got %b want %b", i, got, want);
    end
  endtask

  task automatic test_load_use();
    in_t st[$]; logic [5:0] xp[$]; in_t s; logic [5:0] got, want;
    s = '0; s.ex_mr = 1'b1; s.ex_rw = 1'b1; s.ex_rd = 5'd8; s.rs = 5'd8;
    st.push_back(s); xp.push_back(V_STALL);
    s = '0; s.mem_mr = 1'b1; s.mem_rd = 5'd8; s.rs = 5'd8;
    st.push_back(s); xp.push_back(V_RUN);
    s = '0; s.ex_mr = 1'b1; s.ex_rw = 1'b1; s.ex_rd = 5'd8; s.rs = 5'd3; s.rt = 5'd8;
    st.push_back(s); xp.push_back(V_RUN);
    s.uses_rt = 1'b1; st.push_back(s); xp.push_back(V_STALL);
    s = '0; s.ex_rw = 1'b1; s.ex_rd = 5'd8; s.rs = 5'd8;
    st.push_back(s); xp.push_back(V_RUN);
    s = '0; s.ex_mr = 1'b1; s.ex_rw = 1'b1; s.ex_rd = 5'd8; s.rs = 5'd8; s.jmp = 1'b1;
    st.push_back(s); xp.push_back(V_STALL);
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1; drive(st[i]); sb.push_back(xp[i]);
      @(negedge clk);
      got = outs(); want = sb.pop_front(); total++;
      if (got === want) passed++;
      else $display("FAIL load_use[%0d]: got %b want %b", i, got, want);
    end
  endtask

  task automatic test_branch_after_load();
    in_t st[$]; logic [5:0] xp[$]; in_t b, s; logic [5:0] got, want;
    b = '0; b.br = 1'b1; b.taken = 1'b1; b.rs = 5'd4; b.rt = 5'd9; b.uses_rt = 1'b1;
    s = b; s.ex_mr = 1'b1; s.ex_rw = 1'b1; s.ex_rd = 5'd9; st.push_back(s); xp.push_back(V_STALL);
    s = b; s.mem_mr = 1'b1; s.mem_rd = 5'd9; st.push_back(s); xp.push_back(V_STALL);
    st.push_back(b); xp.push_back(V_XFER);
    s = b; s.taken = 1'b0; s.ex_rw = 1'b1; s.ex_rd = 5'd4; st.push_back(s); xp.push_back(V_STALL);
    s = b; s.taken = 1'b0; st.push_back(s); xp.push_back(V_RUN);
    s = '0; s.jmp = 1'b1; st.push_back(s); xp.push_back(V_XFER);
    s = b; s.uses_rt = 1'b0; s.mem_mr = 1'b1; s.mem_rd = 5'd9; st.push_back(s); xp.push_back(V_XFER);
    s = b; s.mem_rd = 5'd9; st.push_back(s); xp.push_back(V_XFER);
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1; drive(st[i]); sb.push_back(xp[i]);
      @(negedge clk);
      got = outs(); want = sb.pop_front(); total++;
      if (got === want) passed++;
      else $display("FAIL branch_after_load[%0d]: got %b want %b", i, got, want);
    end
  endtask

  task automatic test_zero_reg();
    in_t st[$]; logic [5:0] xp[$]; in_t s; logic [5:0] got, want;
    s = '0; s.ex_mr = 1'b1; s.ex_rw = 1'b1; st.push_back(s); xp.push_back(V_RUN);
    s = '0; s.br = 1'b1; s.uses_rt = 1'b1; s.ex_rw = 1'b1; s.mem_mr = 1'b1;
    st.push_back(s); xp.push_back(V_RUN);
    s = '0; s.ex_mr = 1'b1; s.ex_rw = 1'b1; s.ex_rd = 5'd31; s.rs = 5'd31;
    st.push_back(s); xp.push_back(V_STALL);
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1; drive(st[i]); sb.push_back(xp[i]);
      @(negedge clk);
      got = outs(); want = sb.pop_front(); total++;
      if (got === want) passed++;
      else $display("FAIL zero_reg[%0d]: got %b want %b", i, got, want);
    end
  endtask

  task automatic test_mem_wait();
    in_t st[$]; logic [5:0] xp[$]; in_t l, s; logic [5:0] got, want;
    l = '0; l.ex_mr = 1'b1; l.ex_rw = 1'b1; l.ex_rd = 5'd8; l.rs = 5'd8;
    s = l; s.busy = 1'b1;
    for (int k = 0; k < 3; k++) begin st.push_back(s); xp.push_back(V_FRZ); end
    st.push_back(l); xp.push_back(V_STALL);
    s = '0; s.mem_mr = 1'b1; s.mem_rd = 5'd8; s.rs = 5'd8; st.push_back(s); xp.push_back(V_RUN);
    s = '0; s.jmp = 1'b1; s.busy = 1'b1; st.push_back(s); xp.push_back(V_FRZ);
    s.busy = 1'b0; st.push_back(s); xp.push_back(V_XFER);
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1; drive(st[i]); sb.push_back(xp[i]);
      @(negedge clk);
      got = outs(); want = sb.pop_front(); total++;
      if (got === want) passed++;
      else $display("FAIL mem_wait[%0d]: got %b want %b", i, got, want);
    end
  endtask

  task automatic test_timeout();
    in_t st[$]; logic [5:0] xp[$]; in_t s; logic [5:0] got, want;
    s = '0; s.busy = 1'b1;
    for (int k = 0; k < 4; k++) begin st.push_back(s); xp.push_back(V_FRZ); end
    s = '0; st.push_back(s); xp.push_back(V_RUN);
    s.busy = 1'b1;
    for (int k = 0; k < 5; k++) begin st.push_back(s); xp.push_back(V_FRZ); end
    s = '0; st.push_back(s); xp.push_back(V_ERR);
    s.jmp = 1'b1; st.push_back(s); xp.push_back(V_ERR);
    s = '0; s.rst = 1'b1; st.push_back(s); xp.push_back(V_RST);
    s = '0; st.push_back(s); xp.push_back(V_RUN);
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1; drive(st[i]); sb.push_back(xp[i]);
      @(negedge clk);
      got = outs(); want = sb.pop_front(); total++;
      if (got === want) passed++;
      else $display("FAIL timeout[%0d]: got %b want %b", i, got, want);
    end
  endtask

  task automatic test_reset_mid_wait();
    in_t st[$]; logic [5:0] xp[$]; in_t s; logic [5:0] got, want;
    s = '0; s.busy = 1'b1; s.jmp = 1'b1;
    st.push_back(s); xp.push_back(V_FRZ);
    st.push_back(s); xp.push_back(V_FRZ);
    s.rst = 1'b1; st.push_back(s); xp.push_back(V_RST);
    s = '0; st.push_back(s); xp.push_back(V_RUN);
    s.busy = 1'b1;
    for (int k = 0; k < 4; k++) begin st.push_back(s); xp.push_back(V_FRZ); end
    s = '0; st.push_back(s); xp.push_back(V_RUN);
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1; drive(st[i]); sb.push_back(xp[i]);
      @(negedge clk);
      got = outs(); want = sb.pop_front(); total++;
      if (got === want) passed++;
      else $display("FAIL reset_mid_wait[%0d]: got %b want %b", i, got, want);
`ifdef HAZARD_PERF_CNT_EN
      if (i == 3) begin
        total++;
        if ({loadUseCnt, branchStallCnt, memWaitCnt, flushCnt} === '0) passed++;
        else $display("FAIL perf_clear: got %0d %0d %0d %0d want all 0",
                      loadUseCnt, branchStallCnt, memWaitCnt, flushCnt);
      end
`endif
    end
  endtask

  initial begin
    in_t s;
    s = '0; s.rst = 1'b1;
    drive(s);
    test_reset();
    test_load_use();
    test_branch_after_load();
    test_zero_reg();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. Drives the PC write enable, the IF/ID stall and flush inputs, the ID/EX bubble insert, and a global freeze for the EX/MEM/WB registers. Detects load-use hazards and branch-operand hazards (branches resolve in ID). Applies control-transfer flushes. Sequences multi-cycle data-memory waits through a small FSM with a timeout watchdog.

Parameters:
MEM_TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before entering ERR.
WAIT_W, 8, width of the wait counter; must satisfy 2^WAIT_W > MEM_TIMEOUT.
PERF_W, 32, width of each performance counter (optional feature only).

Ports:
clk  in  1  pipeline clock; all state updates on posedge.
reset  in  1  synchronous, active-high.
idRs  in  5  rs field of the instruction in ID.
idRt  in  5  rt field of the instruction in ID.
idUsesRt  in  1  ID instruction reads rt as a source.
idBranch  in  1  ID holds beq/bne.
idBranchTaken  in  1  ID branch comparison result.
idJump  in  1  ID holds j/jal/jr.
exMemRead  in  1  EX instruction is a load.
exRegWrite  in  1  EX instruction writes a register.
exRd  in  5  destination register of the EX instruction.
memMemRead  in  1  MEM instruction is a load.
memRd  in  5  destination register of the MEM instruction.
dmemBusy  in  1  data memory not ready this cycle.
pcWrite  out  1  PC update enable.
ifidStall  out  1  to IF/ID stall.
ifidFlush  out  1  to IF/ID flush.
idexFlush  out  1  inserts a bubble into ID/EX.
pipeFreeze  out  1  holds ID/EX, EX/MEM and MEM/WB.
hazardErr  out  1  sticky memory-timeout error.

Behaviour:
- Reset is synchronous and active-high. While reset=1: state=RUN, waitCnt=0, hazardErr=0. Outputs are forced to pcWrite=0, ifidStall=0, ifidFlush=1, idexFlush=1, pipeFreeze=0.
- match(r) = (r!=0) && (r==idRs || (idUsesRt && r==idRt)).
- loadUse = exMemRead && match(exRd).
- branchHaz = idBranch && ((exRegWrite && match(exRd)) || (memMemRead && match(memRd))). A branch directly after a load therefore stalls 2 cycles.
- FSM states: RUN, MEM_WAIT, ERR.
  - RUN -> MEM_WAIT on dmemBusy=1.
  - MEM_WAIT -> RUN on dmemBusy=0.
  - MEM_WAIT -> ERR when waitCnt==MEM_TIMEOUT-1 and dmemBusy=1.
  - ERR is absorbing until reset.
- waitCnt clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.
- Output priority is evaluated combinationally every cycle, highest first:
  1. state==ERR: pcWrite=0, ifidStall=1, pipeFreeze=1, flushes=0, hazardErr=1.
  2. dmemBusy=1 (RUN or MEM_WAIT): pcWrite=0, ifidStall=1, pipeFreeze=1, ifidFlush=0, idexFlush=0. Freeze takes effect in the first busy cycle; hazards and flushes are suppressed and re-evaluated after release.
  3. loadUse or branchHaz: pcWrite=0, ifidStall=1, idexFlush=1, ifidFlush=0, pipeFreeze=0.
  4. (idBranch && idBranchTaken) or idJump: pcWrite=1, ifidFlush=1, ifidStall=0, idexFlush=0.
  5. Otherwise: pcWrite=1, all other outputs 0.
- ifidStall and ifidFlush are never both 1.
- Register $0 never causes a hazard.
- A hazard condition does not change FSM state.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds output ports loadUseCnt, branchStallCnt, memWaitCnt and flushCnt, each PERF_W bits. Each counter increments once per cycle in which priority 3 fires due to loadUse, priority 3 fires due to branchHaz only, priority 2 fires, or priority 4 fires, respectively. All counters clear on reset and saturate at all-ones.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared header `pipeline_defs.vh` holds:
  - FSM state encodings: RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2.
  - REG_ZERO=5'd0.
  - Register-index width 5.
- Sub-module hazard_match (combinational) computes match(r) for the rs/rt comparison. It is instantiated three times: exRd for loadUse, exRd for branchHaz, memRd for branchHaz.

Test Plan:
- Load-use: exMemRead=1, exRd=8, idRs=8 -> one cycle of pcWrite=0, ifidStall=1, idexFlush=1; next cycle (load moved to MEM) all stalls clear.
- Branch after load: idBranch=1, idRt=9, idUsesRt=1; load to $9 in EX, then in MEM -> two consecutive stall cycles, then pcWrite=1. If idBranchTaken=1, the following cycle has ifidFlush=1.
- $0 immunity: exMemRead=1, exRd=0, idRs=0 -> no stall; pcWrite=1.
- Memory wait with simultaneous hazard: dmemBusy=1 for 3 cycles while loadUse is true -> pipeFreeze=1 and idexFlush=0 for 3 cycles; after release, the loadUse stall is applied once.
- Timeout: MEM_TIMEOUT=4, dmemBusy held at 1 -> hazardErr=1 after the 4th MEM_WAIT cycle and stays 1 when dmemBusy drops. Reset clears it, and the first cycle after reset has pcWrite=1.
- Reset mid-MEM_WAIT: reset=1 during a busy cycle -> ifidFlush=1, idexFlush=1, pipeFreeze=0 in that cycle, state=RUN afterwards. With HAZARD_PERF_CNT_EN, all counters read 0.
